// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbitrated bank of SR flag bits with illegal-command trap
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int RW    = 2,
  parameter int NFLAG = 8,
  parameter int IW    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IW*NREQ-1:0]   idx,
  output logic [NFLAG-1:0]     flags,
  output logic [NREQ-1:0]      gnt,
  output logic                 err,
  output logic [RW-1:0]        err_src,
  output logic [7:0]           err_cnt
);

  logic [RW-1:0]   ptr;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [RW-1:0]   win;
  logic [RW-1:0]   cand;
  logic [1:0]      win_op;
  logic [IW-1:0]   win_idx;

  // Pick the first eligible requester at or after ptr; the just-granted one sits out a cycle.
  always_comb begin
    elig  = req & ~gnt;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + RW'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_op  = op[2*win +: 2];
    win_idx = idx[IW*win +: IW];
  end

  // Apply the winner's command, advance the pointer and trap S=R=1 without touching the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags   <= '0;
      gnt     <= '0;
      err     <= 1'b0;
      err_src <= '0;
      err_cnt <= '0;
      ptr     <= '0;
    end else begin
      gnt <= '0;
      err <= 1'b0;
      if (found) begin
        gnt <= NREQ'(1) << win;
        ptr <= win + RW'(1);
        case (win_op)
          2'b10:   flags[win_idx] <= 1'b1;
          2'b01:   flags[win_idx] <= 1'b0;
          2'b11: begin
            err     <= 1'b1;
            err_src <= win;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - table-driven scoreboard bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [11:0] idx;
  logic [7:0]  flags;
  logic [3:0]  gnt;
  logic        err;
  logic [1:0]  err_src;
  logic [7:0]  err_cnt;

  int checks;
  int errors;

  typedef struct packed {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic [7:0]  flags;
    logic        err;
    logic [1:0]  src;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  sr_flag_arbiter #(.NREQ(4), .RW(2), .NFLAG(8), .IW(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .idx     (idx),
    .flags   (flags),
    .gnt     (gnt),
    .err     (err),
    .err_src (err_src),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [7:0] o, input logic [11:0] i,
                              input logic [3:0] g, input logic [7:0] f, input logic e,
                              input logic [1:0] s, input logic [7:0] c);
    vec_t v;
    v.req = r; v.op = o; v.idx = i; v.gnt = g; v.flags = f; v.err = e; v.src = s; v.cnt = c;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    sb.push_back(v);
    req = v.req;
    op  = v.op;
    idx = v.idx;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk({tag, " gnt"},     32'(gnt),     32'(e.gnt));
      chk({tag, " flags"},   32'(flags),   32'(e.flags));
      chk({tag, " err"},     32'(err),     32'(e.err));
      chk({tag, " err_src"}, 32'(err_src), 32'(e.src));
      chk({tag, " err_cnt"}, 32'(err_cnt), 32'(e.cnt));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    req = '0;
    op  = '0;
    idx = '0;

    // single set from requester 0
    tbl.push_back(mk(4'h1, 8'h02, 12'h005, 4'h1, 8'h20, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'h20, 1'b0, 2'd0, 8'd0));
    // all four hold req with set commands on flags 0..3; ptr starts at 1
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h2, 8'h22, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h4, 8'h26, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h8, 8'h2E, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h1, 8'h2F, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h2, 8'h2F, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h4, 8'h2F, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h8, 8'h2F, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'hF, 8'hAA, 12'h688, 4'h1, 8'h2F, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'h2F, 1'b0, 2'd0, 8'd0));
    // requester 1 holds a reset of flag 0: granted every other cycle
    tbl.push_back(mk(4'h2, 8'h04, 12'h000, 4'h2, 8'h2E, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'h2, 8'h04, 12'h000, 4'h0, 8'h2E, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'h2, 8'h04, 12'h000, 4'h2, 8'h2E, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'h2, 8'h04, 12'h000, 4'h0, 8'h2E, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'h2, 8'h04, 12'h000, 4'h2, 8'h2E, 1'b0, 2'd0, 8'd0));
    tbl.push_back(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'h2E, 1'b0, 2'd0, 8'd0));
    // illegal S=R=1 from requester 2 on flag 7
    tbl.push_back(mk(4'h4, 8'h30, 12'h1C0, 4'h4, 8'h2E, 1'b1, 2'd2, 8'd1));
    tbl.push_back(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'h2E, 1'b0, 2'd2, 8'd1));
    // hold command from requester 3 on flag 4
    tbl.push_back(mk(4'h8, 8'h00, 12'h800, 4'h8, 8'h2E, 1'b0, 2'd2, 8'd1));
    // requesters 0 and 1 together with ptr=0
    tbl.push_back(mk(4'h3, 8'h0A, 12'h03E, 4'h1, 8'h6E, 1'b0, 2'd2, 8'd1));
    tbl.push_back(mk(4'h3, 8'h0A, 12'h03E, 4'h2, 8'hEE, 1'b0, 2'd2, 8'd1));
    tbl.push_back(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'hEE, 1'b0, 2'd2, 8'd1));
    // ptr=2: search wraps 2,3,0 to grant requester 0
    tbl.push_back(mk(4'h3, 8'h0A, 12'h03E, 4'h1, 8'hEE, 1'b0, 2'd2, 8'd1));
    tbl.push_back(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'hEE, 1'b0, 2'd2, 8'd1));

    // reset state
    #12;
    chk("reset flags",   32'(flags),   32'(0));
    chk("reset gnt",     32'(gnt),     32'(0));
    chk("reset err",     32'(err),     32'(0));
    chk("reset err_src", 32'(err_src), 32'(0));
    chk("reset err_cnt", 32'(err_cnt), 32'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // counter saturation: requester 3 issues S=R=1 300 times (ptr=1 here)
    for (int n = 0; n < 300; n++) begin
      apply(mk(4'h8, 8'hC0, 12'hE00, 4'h8, 8'hEE, 1'b1, 2'd3, (n + 2 > 255) ? 8'd255 : 8'(n + 2)), "sat_hit");
      apply(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'hEE, 1'b0, 2'd3, (n + 2 > 255) ? 8'd255 : 8'(n + 2)), "sat_idle");
    end

    // move ptr off zero, then reset asynchronously mid-cycle
    apply(mk(4'hF, 8'hAA, 12'h688, 4'h1, 8'hEF, 1'b0, 2'd3, 8'd255), "pre_rst");
    req = 4'hF;
    #2;
    rst = 1'b0;
    #1;
    chk("async flags",   32'(flags),   32'(0));
    chk("async gnt",     32'(gnt),     32'(0));
    chk("async err",     32'(err),     32'(0));
    chk("async err_src", 32'(err_src), 32'(0));
    chk("async err_cnt", 32'(err_cnt), 32'(0));
    @(posedge clk);
    #1;
    chk("in_rst gnt",   32'(gnt),   32'(0));
    chk("in_rst flags", 32'(flags), 32'(0));
    #2;
    rst = 1'b1;
    #1;
    apply(mk(4'hF, 8'hAA, 12'h688, 4'h1, 8'h01, 1'b0, 2'd0, 8'd0), "post_rst0");
    apply(mk(4'hF, 8'hAA, 12'h688, 4'h2, 8'h03, 1'b0, 2'd0, 8'd0), "post_rst1");
    apply(mk(4'h0, 8'h00, 12'h000, 4'h0, 8'h03, 1'b0, 2'd0, 8'd0), "post_rst2");

    chk("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
